// File: rtl/reg_targetio_ctrl.sv
// Target-IO controller on the 8-bit register bus.
// Provides a drive mode per line, a synchroniser and stability filter per line,
// a maskable AND/OR trigger combiner and a sticky trigger-seen flag.
module reg_targetio_ctrl #(
    parameter int unsigned NUM_IO       = 4,
    parameter int unsigned FILTER_W     = 8,
    parameter logic [5:0]  ADDR_IOMODE  = 6'd58,
    parameter logic [5:0]  ADDR_TRIGCFG = 6'd59,
    parameter logic [5:0]  ADDR_STATUS  = 6'd60
) (
    input  logic              clk,
    input  logic              reset_i,
    input  logic [5:0]        reg_address,
    input  logic [15:0]       reg_bytecnt,
    input  logic [7:0]        reg_datai,
    output logic [7:0]        reg_datao,
    input  logic [15:0]       reg_size,
    input  logic              reg_read,
    input  logic              reg_write,
    input  logic              reg_addrvalid,
    input  logic [5:0]        reg_hypaddress,
    output logic [15:0]       reg_hyplen,
    output logic              reg_stream,
    input  logic [NUM_IO-1:0] io_in_i,
    input  logic [NUM_IO-1:0] io_src_i,
    input  logic              target_highz_i,
    output logic [NUM_IO-1:0] io_out_o,
    output logic [NUM_IO-1:0] io_oe_o,
    output logic [NUM_IO-1:0] io_level_o,
    output logic              trigger_o
);

    // Filter length arrives as a byte; widen so saturation works for any FILTER_W.
    localparam int unsigned      EXT_W    = (FILTER_W > 8) ? FILTER_W : 8;
    localparam logic [EXT_W-1:0] FLEN_MAX = EXT_W'((64'(1) << FILTER_W) - 64'(1));

    logic [NUM_IO-1:0][1:0]          mode_q;
    logic [NUM_IO-1:0]               mask_q;
    logic                            combine_q;
    logic                            invert_q;
    logic [FILTER_W-1:0]             flen_q;
    logic                            sticky_q, sticky_d;
    logic                            trig_q, trig_d;
    logic [NUM_IO-1:0]               sync1_q, sync2_q;
    logic [NUM_IO-1:0]               level_q, level_d;
    logic [NUM_IO-1:0][FILTER_W-1:0] cnt_q, cnt_d;
    logic [7:0]                      datao_q, datao_d;

    logic                wr_en;
    logic                wr_iomode, wr_trig, wr_clr;
    logic [EXT_W-1:0]    datai_ext;
    logic [FILTER_W-1:0] flen_wr;
    logic                comb_or, comb_and, comb;
    logic                unused_size;

    assign unused_size = ^reg_size;
    assign reg_stream  = 1'b0;
    assign reg_datao   = datao_q;
    assign io_level_o  = level_q;
    assign trigger_o   = trig_q;

    // Write strobes and saturated filter length.
    always_comb begin
        wr_en     = reg_write & reg_addrvalid;
        wr_iomode = wr_en && (reg_address == ADDR_IOMODE);
        wr_trig   = wr_en && (reg_address == ADDR_TRIGCFG);
        wr_clr    = wr_en && (reg_address == ADDR_STATUS) && (reg_bytecnt == 16'd1)
                    && reg_datai[0];
        datai_ext = EXT_W'(reg_datai);
        flen_wr   = (datai_ext > FLEN_MAX) ? FLEN_MAX[FILTER_W-1:0] : datai_ext[FILTER_W-1:0];
    end

    // Configuration registers; byte indices past each register's length match nothing.
    always_ff @(posedge clk) begin
        if (reset_i) begin
            mode_q    <= '0;
            mask_q    <= '0;
            combine_q <= 1'b0;
            invert_q  <= 1'b0;
            flen_q    <= '0;
        end else begin
            if (wr_iomode) begin
                for (int n = 0; n < int'(NUM_IO); n++) begin
                    if (reg_bytecnt == 16'(n)) begin
                        mode_q[n] <= reg_datai[1:0];
                    end
                end
            end
            if (wr_trig) begin
                case (reg_bytecnt)
                    16'd0: mask_q <= reg_datai[NUM_IO-1:0];
                    16'd1: begin
                        combine_q <= reg_datai[0];
                        invert_q  <= reg_datai[1];
                    end
                    16'd2: flen_q <= flen_wr;
                    default: ;
                endcase
            end
        end
    end

    // Drive path: purely combinational so passthrough sources see no added latency.
    always_comb begin
        io_out_o = '0;
        io_oe_o  = '0;
        for (int n = 0; n < int'(NUM_IO); n++) begin
            case (mode_q[n])
                2'd1:    io_out_o[n] = io_src_i[n] & ~target_highz_i;
                2'd3:    io_out_o[n] = ~target_highz_i;
                default: io_out_o[n] = 1'b0;
            endcase
            io_oe_o[n] = (mode_q[n] != 2'd0) & ~target_highz_i;
        end
    end

    // Stability filter next state: a change is accepted once it has persisted past L compares.
    always_comb begin
        level_d = level_q;
        cnt_d   = cnt_q;
        for (int n = 0; n < int'(NUM_IO); n++) begin
            if (sync2_q[n] != level_q[n]) begin
                // >= so that lowering L below a running count still takes effect
                if (cnt_q[n] >= flen_q) begin
                    level_d[n] = sync2_q[n];
                    cnt_d[n]   = '0;
                end else begin
                    cnt_d[n] = cnt_q[n] + FILTER_W'(1);
                end
            end else begin
                cnt_d[n] = '0;
            end
        end
    end

    // Synchroniser, filter counters and filtered levels.
    always_ff @(posedge clk) begin
        if (reset_i) begin
            sync1_q <= '0;
            sync2_q <= '0;
            level_q <= '0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= io_in_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    // Trigger combiner and sticky flag next state; a rising edge beats a clear.
    always_comb begin
        comb_or  = |(level_q & mask_q);
        comb_and = &(level_q | ~mask_q);
        comb     = combine_q ? comb_and : comb_or;
        trig_d   = (mask_q == '0) ? 1'b0 : (comb ^ invert_q);
        sticky_d = sticky_q;
        if (wr_clr) begin
            sticky_d = 1'b0;
        end
        if (trig_d & ~trig_q) begin
            sticky_d = 1'b1;
        end
    end

    // Trigger output and sticky flag registers.
    always_ff @(posedge clk) begin
        if (reset_i) begin
            trig_q   <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            trig_q   <= trig_d;
            sticky_q <= sticky_d;
        end
    end

    // Read mux: zero unless this block owns an in-range byte being read (OR-bus safe).
    always_comb begin
        datao_d = '0;
        if (reg_read && reg_addrvalid) begin
            if (reg_address == ADDR_IOMODE) begin
                for (int n = 0; n < int'(NUM_IO); n++) begin
                    if (reg_bytecnt == 16'(n)) begin
                        datao_d = {6'b0, mode_q[n]};
                    end
                end
            end else if (reg_address == ADDR_TRIGCFG) begin
                case (reg_bytecnt)
                    16'd0:   datao_d = 8'(mask_q);
                    16'd1:   datao_d = {6'b0, invert_q, combine_q};
                    16'd2:   datao_d = 8'(flen_q);
                    default: datao_d = '0;
                endcase
            end else if (reg_address == ADDR_STATUS) begin
                case (reg_bytecnt)
                    16'd0:   datao_d = 8'(level_q);
                    16'd1:   datao_d = {7'b0, sticky_q};
                    default: datao_d = '0;
                endcase
            end
        end
    end

    // Registered read data, one cycle behind address.
    always_ff @(posedge clk) begin
        if (reset_i) begin
            datao_q <= '0;
        end else begin
            datao_q <= datao_d;
        end
    end

    // Register length lookup for the hypothetical address.
    always_comb begin
        reg_hyplen = '0;
        if (reg_hypaddress == ADDR_IOMODE) begin
            reg_hyplen = 16'(NUM_IO);
        end else if (reg_hypaddress == ADDR_TRIGCFG) begin
            reg_hyplen = 16'd3;
        end else if (reg_hypaddress == ADDR_STATUS) begin
            reg_hyplen = 16'd2;
        end
    end

endmodule
